// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Asynchronous serial receiver feeding a first-word-fall-through FIFO.
//
// The serial line is brought into the i_clk domain through a two-flop
// synchroniser. A baud-counter driven FSM samples the start bit at half a bit
// period, then every data, parity and stop bit at mid-bit. Good frames are
// pushed into a 2**LGFLEN deep FIFO whose head entry is always presented on
// o_data. Framing, parity and overrun problems raise sticky flags that stay
// set until i_clr_err.
//
// Parameters
//   CLOCKS_PER_BAUD  i_clk cycles per bit period (>= 8)
//   DATA_BITS        data bits per frame (5..8)
//   PARITY           0 none, 1 odd, 2 even
//   LGFLEN           log2 of FIFO depth
//
// Ports
//   i_clk         clock, all logic on its rising edge
//   i_rst_n       asynchronous active-low reset
//   i_uart_rx     serial input, idle high, asynchronous to i_clk
//   i_rd          pop the head entry (ignored when empty)
//   i_clr_err     clear all sticky error flags
//   o_data        head entry of the FIFO
//   o_empty_n     FIFO holds at least one entry
//   o_full        FIFO holds 2**LGFLEN entries
//   o_fill        current entry count
//   o_frame_err   sticky: stop bit sampled low
//   o_parity_err  sticky: parity bit mismatched
//   o_overrun     sticky: frame arrived while FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104,
    parameter int          DATA_BITS       = 8,
    parameter int          PARITY          = 0,
    parameter logic [3:0]  LGFLEN          = 4'd3
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_uart_rx,
    input  logic                 i_rd,
    input  logic                 i_clr_err,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_empty_n,
    output logic                 o_full,
    output logic [LGFLEN:0]      o_fill,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun
);

    localparam int PTR_W  = int'(LGFLEN);
    localparam int FILL_W = PTR_W + 1;
    localparam int DEPTH  = 1 << PTR_W;

    // First sample lands mid start bit; later ones one full period apart.
    localparam logic [23:0]       HALF_BAUD    = CLOCKS_PER_BAUD >> 1;
    localparam logic [23:0]       FULL_BAUD_M1 = CLOCKS_PER_BAUD - 24'd1;
    localparam logic [3:0]        LAST_BIT     = 4'(DATA_BITS - 1);
    localparam logic [FILL_W-1:0] FULL_COUNT   = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] ONE_ENTRY    = FILL_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE      = PTR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } rx_state_t;

    // -------------------------------------------------------------------------
    // Line synchroniser and edge history
    // -------------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // -------------------------------------------------------------------------
    // Receiver FSM
    // -------------------------------------------------------------------------
    rx_state_t            state;
    logic [23:0]          baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 parity_bad;
    logic                 wr_pulse;
    logic                 baud_tick;

    assign baud_tick = (baud_cnt == 24'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            baud_cnt   <= 24'd0;
            bit_cnt    <= 4'd0;
            rx_shift   <= '0;
            parity_bad <= 1'b0;
            wr_pulse   <= 1'b0;
        end else begin
            wr_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state    <= START;
                        baud_cnt <= HALF_BAUD;
                    end
                end

                START: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else if (!rx_sync) begin
                        state      <= DATA;
                        baud_cnt   <= FULL_BAUD_M1;
                        bit_cnt    <= 4'd0;
                        parity_bad <= 1'b0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state <= IDLE;
                    end
                end

                DATA: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else begin
                        // LSB arrives first, so shift in from the top.
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                        baud_cnt <= FULL_BAUD_M1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end

                PAR: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else begin
                        // Odd parity wants an odd total count of ones over
                        // data plus parity bit; even wants an even total.
                        if (PARITY == 1) begin
                            parity_bad <= ~(^rx_shift ^ rx_sync);
                        end else begin
                            parity_bad <= ^rx_shift ^ rx_sync;
                        end
                        baud_cnt <= FULL_BAUD_M1;
                        state    <= STOP;
                    end
                end

                STOP: begin
                    if (!baud_tick) begin
                        baud_cnt <= baud_cnt - 24'd1;
                    end else if (rx_sync) begin
                        wr_pulse <= !parity_bad;
                        state    <= IDLE;
                    end else begin
                        state <= BREAK;
                    end
                end

                BREAK: begin
                    // Wait out a held-low line so it is not taken as a start.
                    if (rx_sync) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // Error events are decided at the stop-bit sample.
    logic stop_tick;
    logic frame_evt;
    logic parity_evt;

    assign stop_tick  = (state == STOP) && baud_tick;
    assign frame_evt  = stop_tick && !rx_sync;
    assign parity_evt = stop_tick && rx_sync && parity_bad;

    // -------------------------------------------------------------------------
    // FIFO
    // -------------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_ptr_nxt;
    logic [FILL_W-1:0]    fill;
    logic                 fifo_full;
    logic                 rd_ok;
    logic                 wr_ok;
    logic                 overrun_evt;

    assign fifo_full   = (fill == FULL_COUNT);
    assign rd_ptr_nxt  = rd_ptr + PTR_ONE;
    assign rd_ok       = i_rd && (fill != '0);
    // A read in the same cycle frees the slot a full FIFO needs.
    assign wr_ok       = wr_pulse && (!fifo_full || rd_ok);
    assign overrun_evt = wr_pulse && fifo_full && !rd_ok;

    // NOTE: the storage array has no reset; only pointers and count define
    // which entries are valid, so clearing the data would add nothing.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
            o_data <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end

            case ({wr_ok, rd_ok})
                2'b10:   fill <= fill + ONE_ENTRY;
                2'b01:   fill <= fill - ONE_ENTRY;
                default: fill <= fill;
            endcase

            // Head register: follow the next entry after a pop, or take the
            // incoming byte when it becomes the head. Otherwise hold, which
            // keeps the last value visible once the FIFO drains.
            if (rd_ok) begin
                if (fill > ONE_ENTRY) begin
                    o_data <= mem[rd_ptr_nxt];
                end else if (wr_ok) begin
                    o_data <= rx_shift;
                end
            end else if (wr_ok && (fill == '0)) begin
                o_data <= rx_shift;
            end
        end
    end

    assign o_fill    = fill;
    assign o_full    = fifo_full;
    assign o_empty_n = (fill != '0);

    // -------------------------------------------------------------------------
    // Sticky error flags: a new event outranks a clear in the same cycle.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            if (frame_evt) begin
                o_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                o_frame_err <= 1'b0;
            end

            if (parity_evt) begin
                o_parity_err <= 1'b1;
            end else if (i_clr_err) begin
                o_parity_err <= 1'b0;
            end

            if (overrun_evt) begin
                o_overrun <= 1'b1;
            end else if (i_clr_err) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo at 16 clocks per bit. Instance u_a runs
// 8N1, instance u_b runs 8E1. Inputs change on the falling clock edge and
// outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx_a, rd_a, clr_a;
    logic       rx_b, rd_b, clr_b;

    logic [7:0] data_a, data_b;
    logic       empty_n_a, empty_n_b;
    logic       full_a, full_b;
    logic [3:0] fill_a, fill_b;
    logic       ferr_a, ferr_b;
    logic       perr_a, perr_b;
    logic       ovr_a, ovr_b;

    uart_rx_fifo #(
        .CLOCKS_PER_BAUD(24'd16),
        .DATA_BITS      (8),
        .PARITY         (0),
        .LGFLEN         (4'd3)
    ) u_a (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (rx_a),
        .i_rd        (rd_a),
        .i_clr_err   (clr_a),
        .o_data      (data_a),
        .o_empty_n   (empty_n_a),
        .o_full      (full_a),
        .o_fill      (fill_a),
        .o_frame_err (ferr_a),
        .o_parity_err(perr_a),
        .o_overrun   (ovr_a)
    );

    uart_rx_fifo #(
        .CLOCKS_PER_BAUD(24'd16),
        .DATA_BITS      (8),
        .PARITY         (2),
        .LGFLEN         (4'd3)
    ) u_b (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (rx_b),
        .i_rd        (rd_b),
        .i_clr_err   (clr_b),
        .o_data      (data_b),
        .o_empty_n   (empty_n_b),
        .o_full      (full_b),
        .o_fill      (fill_b),
        .o_frame_err (ferr_b),
        .o_parity_err(perr_b),
        .o_overrun   (ovr_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rx(input bit inst_b, input logic v);
        if (inst_b) rx_b = v;
        else        rx_a = v;
    endtask

    task automatic hold(input int periods);
        repeat (CPB * periods) @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit, then the stop
    // bit: held low for stop_low periods first when forcing a framing error.
    task automatic send_frame(input bit inst_b, input logic [7:0] d, input bit with_par,
                              input logic par, input int stop_low);
        set_rx(inst_b, 1'b0);
        hold(1);
        for (int i = 0; i < 8; i++) begin
            set_rx(inst_b, d[i]);
            hold(1);
        end
        if (with_par) begin
            set_rx(inst_b, par);
            hold(1);
        end
        if (stop_low > 0) begin
            set_rx(inst_b, 1'b0);
            hold(stop_low);
        end
        set_rx(inst_b, 1'b1);
        hold(1);
    endtask

    task automatic pop_a();
        rd_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0;
    endtask

    task automatic clear_a();
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
    endtask

    task automatic clear_b();
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rd_a  = 1'b0;
        rd_b  = 1'b0;
        clr_a = 1'b0;
        clr_b = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(4);

        // Reset state
        check("rst_fill",    32'(fill_a), 'h0);
        check("rst_empty_n", 32'(empty_n_a), 'h0);
        check("rst_full",    32'(full_a), 'h0);
        check("rst_data",    32'(data_a), 'h0);
        check("rst_flags",   32'({ferr_a, perr_a, ovr_a}), 'h0);

        // Pop on an empty FIFO is ignored
        pop_a();
        check("empty_rd_fill",  32'(fill_a), 'h0);
        check("empty_rd_flags", 32'({ferr_a, perr_a, ovr_a}), 'h0);

        // Single 8N1 byte
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 0);
        check("a5_data",    32'(data_a), 'hA5);
        check("a5_fill",    32'(fill_a), 'h1);
        check("a5_empty_n", 32'(empty_n_a), 'h1);
        pop_a();
        check("a5_pop_fill",    32'(fill_a), 'h0);
        check("a5_pop_empty_n", 32'(empty_n_a), 'h0);
        check("a5_pop_hold",    32'(data_a), 'hA5);

        // Four-cycle low glitch on an idle line
        rx_a = 1'b0;
        idle_cycles(4);
        rx_a = 1'b1;
        hold(2);
        check("glitch_fill",  32'(fill_a), 'h0);
        check("glitch_flags", 32'({ferr_a, perr_a, ovr_a}), 'h0);

        // Nine bytes into an eight-deep FIFO
        for (int b = 1; b <= 9; b++) begin
            send_frame(1'b0, 8'(b), 1'b0, 1'b0, 0);
        end
        check("ovr_fill",  32'(fill_a), 'h8);
        check("ovr_full",  32'(full_a), 'h1);
        check("ovr_flag",  32'(ovr_a), 'h1);
        check("ovr_ferr",  32'(ferr_a), 'h0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovr_rd%0d", i), 32'(data_a), 32'(i));
            pop_a();
        end
        check("ovr_drain_fill", 32'(fill_a), 'h0);
        check("ovr_drain_full", 32'(full_a), 'h0);
        check("ovr_drain_hold", 32'(data_a), 'h8);
        clear_a();
        check("ovr_clr", 32'(ovr_a), 'h0);

        // Stop bit held low for three periods, then a good byte
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 3);
        hold(1);
        check("frm_flag", 32'(ferr_a), 'h1);
        check("frm_fill", 32'(fill_a), 'h0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 0);
        check("frm_next_data", 32'(data_a), 'h55);
        check("frm_next_fill", 32'(fill_a), 'h1);
        check("frm_sticky",    32'(ferr_a), 'h1);
        pop_a();

        // Even parity: 0x07 has three ones, so the parity bit must be 1
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 0);
        check("par_flag", 32'(perr_b), 'h1);
        check("par_fill", 32'(fill_b), 'h0);
        clear_b();
        check("par_clr", 32'(perr_b), 'h0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 0);
        check("par_good_fill", 32'(fill_b), 'h1);
        check("par_good_data", 32'(data_b), 'h07);
        check("par_good_flag", 32'(perr_b), 'h0);

        // Reset in the middle of a frame with two entries stored
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 0);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 0);
        check("mid_pre_fill", 32'(fill_a), 'h2);
        set_rx(1'b0, 1'b0);
        hold(1);
        set_rx(1'b0, 1'b1);
        hold(1);
        set_rx(1'b0, 1'b0);
        hold(1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fill",    32'(fill_a), 'h0);
        check("mid_rst_empty_n", 32'(empty_n_a), 'h0);
        check("mid_rst_full",    32'(full_a), 'h0);
        check("mid_rst_data",    32'(data_a), 'h0);
        check("mid_rst_flags",   32'({ferr_a, perr_a, ovr_a}), 'h0);
        check("mid_rst_b_fill",  32'(fill_b), 'h0);
        rx_a = 1'b1;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(20);
        check("mid_post_fill", 32'(fill_a), 'h0);
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 0);
        check("mid_post_data",  32'(data_a), 'h81);
        check("mid_post_fill1", 32'(fill_a), 'h1);
        check("mid_post_flags", 32'({ferr_a, perr_a, ovr_a}), 'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 24'd104: i_clk cycles per bit period, legal range >= 8.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter LGFLEN, default 4'd3: FIFO depth = 2**LGFLEN entries.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port i_uart_rx, input, 1: asynchronous serial line, idle high.
REQ-008 SHALL have port i_rd, input, 1: pop request.
REQ-009 SHALL have port i_clr_err, input, 1: clears all sticky error flags.
REQ-010 SHALL have port o_data, output, DATA_BITS: oldest FIFO entry (first-word-fall-through).
REQ-011 SHALL have port o_empty_n, output, 1: FIFO holds >= 1 entry.
REQ-012 SHALL have port o_full, output, 1: FIFO holds 2**LGFLEN entries.
REQ-013 SHALL have port o_fill, output, LGFLEN+1: current entry count.
REQ-014 SHALL have port o_frame_err, output, 1: sticky framing-error flag.
REQ-015 SHALL have port o_parity_err, output, 1: sticky parity-error flag.
REQ-016 SHALL have port o_overrun, output, 1: sticky overrun flag.

Function
REQ-017 SHALL pass i_uart_rx through a 2-flop synchroniser; all receiver decisions use the synchronised value.
REQ-018 Receiver FSM SHALL have states IDLE, START, DATA, PAR, STOP, BREAK.
REQ-019 IDLE->START on synchronised high-to-low transition; baud counter loads CLOCKS_PER_BAUD/2 (integer division).
REQ-020 START: at counter expiry, line low -> DATA with counter reloaded to CLOCKS_PER_BAUD-1; line high -> IDLE, glitch rejected, no flag.
REQ-021 DATA: one sample per bit period, LSB first, exactly DATA_BITS samples; then PAR if PARITY!=0, else STOP.
REQ-022 PAR: sample one bit; mismatch against odd/even parity of the data bits marks the frame bad-parity.
REQ-023 STOP: sample one bit; high and parity good -> write pulse, IDLE; high and parity bad -> no write, o_parity_err<=1, IDLE; low -> no write, o_frame_err<=1, BREAK.
REQ-024 BREAK SHALL remain until the synchronised line is high, then IDLE; no start detection while in BREAK.
REQ-025 Write pulse SHALL assert the cycle after the stop-bit sample; o_empty_n and o_data valid from the cycle after the write pulse.
REQ-026 FIFO pointers SHALL be LGFLEN bits and wrap modulo 2**LGFLEN; o_fill SHALL equal writes minus reads accepted.
REQ-027 i_rd with o_empty_n=0 SHALL be ignored, no state change, no flag.
REQ-028 Write with o_full=1 and no simultaneous accepted read: byte dropped, FIFO unchanged, o_overrun<=1.
REQ-029 Write and read in the same cycle when full: both accepted, o_fill unchanged; when empty: write accepted, read ignored, o_fill becomes 1.
REQ-030 o_data SHALL update one cycle after an accepted read, to the next entry, or hold its previous value if the FIFO becomes empty.
REQ-031 i_clr_err=1 SHALL clear all three flags; an error event in the same cycle SHALL win, leaving that flag set.

Reset
REQ-032 i_rst_n=0 SHALL immediately force FSM=IDLE, pointers=0, o_fill=0, o_empty_n=0, o_full=0, o_data=0, all flags=0, synchroniser flops=1.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release the receiver waits for a fresh falling edge.

Verification (CLOCKS_PER_BAUD=16, DATA_BITS=8, LGFLEN=3 unless noted)
REQ-034 Send 0xA5 8N1 -> write pulse once; o_data=0xA5, o_fill=1, o_empty_n=1 by two cycles after the stop-bit sample; i_rd -> o_fill=0.
REQ-035 Send 9 bytes 0x01..0x09 with no reads -> o_fill=8, o_full=1, o_overrun=1; 8 reads return 0x01..0x08 in order.
REQ-036 Send 0x3C with stop bit held low for 3 bit periods -> o_frame_err=1, o_fill=0; next valid 0x55 -> o_data=0x55.
REQ-037 PARITY=2, send 0x07 with parity bit 0 -> o_parity_err=1, o_fill=0; i_clr_err pulse -> flag 0.
REQ-038 4-cycle low glitch on idle line -> no write, no flag, FSM returns to IDLE.
REQ-039 Assert i_rst_n=0 during the DATA state with 2 entries stored -> all outputs at reset values; next 0x81 frame -> o_data=0x81, o_fill=1.
